poly_operand_driver: RTL and testbench

//  Initiator side of the go/data operand handshake of the quadratic evaluator (A*X^2+B*X+C).

---
 rtl/poly_pkg.sv | 32 +++
 rtl/poly_if.sv | 11 +
 rtl/poly_golden.sv | 19 +
 rtl/poly_operand_driver.sv | 155 +++++++++++++++
 tb/tb_poly_operand_driver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_pkg.sv
// Shared definitions for the quadratic-evaluator operand driver:
// FSM state encoding, operand slot indices and default sizing.
package poly_pkg;

    localparam int POLY_WIDTH          = 8;
    localparam int POLY_RESULT_LAT_MIN = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        GO_HI    = 3'd2,
        GAP      = 3'd3,
        WAIT_RES = 3'd4,
        RESP     = 3'd5
    } state_t;

    // Operands go out in this fixed order: A, B, C, X.
    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_X = 2'd3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/poly_if.sv
// Go/data operand bus between the driver (master) and the evaluator (slave).
interface poly_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] calc_data;
    logic             calc_go;
    logic [WIDTH-1:0] calc_result;

    modport master (output calc_data, output calc_go, input calc_result);
    modport slave  (input calc_data, input calc_go, output calc_result);
endinterface

// File: rtl/poly_golden.sv
// Reference A*X*X + B*X + C, every product and sum truncated to WIDTH bits.
module poly_golden #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] x_sq;
    logic [WIDTH-1:0] a_term;
    logic [WIDTH-1:0] b_term;

    assign x_sq   = x * x;
    assign a_term = a * x_sq;
    assign b_term = b * x;
    assign y      = a_term + b_term + c;
endmodule

// File: rtl/poly_operand_driver.sv
// Initiator of the go/data operand handshake: takes one {A,B,C,X} request,
// serialises it onto the evaluator bus, waits the compute latency, captures
// the result and returns it alongside a golden value and a mismatch flag.
module poly_operand_driver
    import poly_pkg::*;
#(
    parameter int WIDTH       = POLY_WIDTH,
    parameter int SETUP_CYC   = 1,
    parameter int GO_HIGH_CYC = 2,
    parameter int GO_LOW_CYC  = 1,
    parameter int RESULT_WAIT = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [WIDTH-1:0] req_c,
    input  logic [WIDTH-1:0] req_x,
    poly_if.master           calc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_expected,
    output logic             rsp_mismatch,
    output logic             busy
);
    localparam int MAX_CYC = max4(SETUP_CYC, GO_HIGH_CYC, GO_LOW_CYC, RESULT_WAIT);
    localparam int TIMER_W = $clog2(MAX_CYC + 1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_load;
    logic               timer_done;
    logic               accept;
    logic [1:0]         idx_q;
    logic [WIDTH-1:0]   op_q [4];
    logic [WIDTH-1:0]   exp_q;
    logic [WIDTH-1:0]   golden_y;
    logic [WIDTH-1:0]   calc_data_q;
    logic               calc_go_q;

    assign accept     = req_valid && req_ready;
    assign timer_done = (timer_q == '0);

    poly_golden #(.WIDTH(WIDTH)) u_golden (
        .a (req_a),
        .b (req_b),
        .c (req_c),
        .x (req_x),
        .y (golden_y)
    );

    // State register plus the single phase timer, reloaded on every state entry.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                timer_q <= timer_load;
            else if (!timer_done)
                timer_q <= timer_q - TIMER_W'(1);
        end
    end

    // Next-state decode.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept)                  state_d = SETUP;
            SETUP:    if (timer_done)              state_d = GO_HI;
            GO_HI:    if (timer_done)              state_d = (idx_q == OP_X) ? WAIT_RES : GAP;
            GAP:      if (timer_done)              state_d = SETUP;
            WAIT_RES: if (timer_done)              state_d = RESP;
            RESP:     if (rsp_valid && rsp_ready)  state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // State-decoded outputs and the timer reload value for the state being entered.
    always_comb begin
        req_ready  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        timer_load = '0;
        case (state_d)
            SETUP:    timer_load = TIMER_W'(SETUP_CYC - 1);
            GO_HI:    timer_load = TIMER_W'(GO_HIGH_CYC - 1);
            GAP:      timer_load = TIMER_W'(GO_LOW_CYC - 1);
            WAIT_RES: timer_load = TIMER_W'(RESULT_WAIT - 1);
            default:  timer_load = '0;
        endcase
    end

    // Operand store, written only on accept.
    // NOTE: no reset on this storage; a reset discards the request and the slots are rewritten before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q[OP_A] <= req_a;
            op_q[OP_B] <= req_b;
            op_q[OP_C] <= req_c;
            op_q[OP_X] <= req_x;
        end
    end

    // Registered bus and response outputs; calc_go tracks GO_HI one edge ahead so it is a clean flop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_q        <= OP_A;
            exp_q        <= '0;
            calc_data_q  <= '0;
            calc_go_q    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_expected <= '0;
            rsp_mismatch <= 1'b0;
        end else begin
            calc_go_q <= (state_d == GO_HI);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        idx_q       <= OP_A;
                        calc_data_q <= req_a;
                        exp_q       <= golden_y;
                    end
                end
                GAP: begin
                    if (timer_done) begin
                        idx_q       <= idx_q + 2'd1;
                        calc_data_q <= op_q[idx_q + 2'd1];
                    end
                end
                WAIT_RES: begin
                    if (timer_done) begin
                        rsp_result   <= calc.calc_result;
                        rsp_expected <= exp_q;
                        rsp_mismatch <= (calc.calc_result != exp_q);
                        rsp_valid    <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign calc.calc_data = calc_data_q;
    assign calc.calc_go   = calc_go_q;

endmodule

// File: tb/tb_poly_operand_driver.sv
// Bench: driver paired with a behavioural evaluator (6-cycle latency after
// the X go pulse falls), directed vector table plus multi-cycle sequences.
module tb_poly_operand_driver;
    import poly_pkg::*;

    localparam int W           = 8;
    localparam int GO_HIGH_CYC = 2;
    localparam int RESULT_WAIT = 7;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0, req_b = '0, req_c = '0, req_x = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result, rsp_expected;
    logic         rsp_mismatch, busy;

    poly_if #(.WIDTH(W)) calc_bus ();

    logic [W-1:0] calc_data;
    logic         calc_go;
    assign calc_data = calc_bus.calc_data;
    assign calc_go   = calc_bus.calc_go;

    poly_operand_driver #(.WIDTH(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .req_x        (req_x),
        .calc         (calc_bus),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_expected (rsp_expected),
        .rsp_mismatch (rsp_mismatch),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- evaluator model ----------------
    function automatic logic [W-1:0] eval_poly(input logic [W-1:0] a, b, c, x);
        logic [W-1:0] t;
        t = a * x;
        t = t + b;
        t = t * x;
        t = t + c;
        return t;
    endfunction

    logic [W-1:0] ev_op [4];
    logic [1:0]   ev_idx = 2'd0;
    logic         ev_arm = 1'b0;
    logic         ev_prev_go = 1'b0;
    int           ev_cnt = 0;
    logic [W-1:0] ev_result = '0;
    logic         ev_corrupt = 1'b0;

    assign calc_bus.calc_result = ev_result;

    always @(posedge clk) begin
        if (!resetn) begin
            ev_idx     <= 2'd0;
            ev_arm     <= 1'b0;
            ev_cnt     <= 0;
            ev_prev_go <= 1'b0;
        end else begin
            ev_prev_go <= calc_go;
            if (calc_go && !ev_prev_go) begin
                ev_op[ev_idx] <= calc_data;
                if (ev_idx == 2'd3) begin
                    ev_idx    <= 2'd0;
                    ev_arm    <= 1'b1;
                    ev_result <= 8'hEE;
                end else begin
                    ev_idx <= ev_idx + 2'd1;
                end
            end
            if (!calc_go && ev_prev_go && ev_arm) begin
                ev_arm <= 1'b0;
                ev_cnt <= 1;
            end else if (ev_cnt == 5) begin
                ev_cnt    <= 0;
                ev_result <= eval_poly(ev_op[0], ev_op[1], ev_op[2], ev_op[3]) + (ev_corrupt ? 8'd1 : 8'd0);
            end else if (ev_cnt != 0) begin
                ev_cnt <= ev_cnt + 1;
            end
        end
    end

    // ---------------- bus monitor (negedge) ----------------
    int           cyc = 0;
    int           mon_pulses = 0, mon_run = 0, mon_viol = 0;
    int           mon_fall_cyc = 0, mon_rsp_cyc = 0;
    logic         mon_prev_go = 1'b0, mon_prev_rsp = 1'b0;
    logic [W-1:0] mon_prev_data = '0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (calc_go && !mon_prev_go) begin
            mon_pulses <= mon_pulses + 1;
            mon_run    <= 1;
        end else if (calc_go) begin
            mon_run <= mon_run + 1;
        end
        if (!calc_go && mon_prev_go) begin
            mon_fall_cyc <= cyc;
            if (mon_run != GO_HIGH_CYC) mon_viol <= mon_viol + 1;
        end
        if ((calc_data != mon_prev_data) && (calc_go || mon_prev_go))
            mon_viol <= mon_viol + 1;
        if (rsp_valid && !mon_prev_rsp) mon_rsp_cyc <= cyc;
        mon_prev_go   <= calc_go;
        mon_prev_data <= calc_data;
        mon_prev_rsp  <= rsp_valid;
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_fail = 0;
    int pulse_base = 0;
    int viol_base  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic [W-1:0] a, b, c, x, input bit keep);
        int n;
        pulse_base = mon_pulses;
        viol_base  = mon_viol;
        req_a = a; req_b = b; req_c = c; req_x = x;
        req_valid = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        check({name, "_accept_cycles"}, n, 1);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic collect(input string name, input logic [W-1:0] res, expd, input logic mm, input int hold);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        check({name, "_rsp_valid"},   rsp_valid, 1);
        check({name, "_go_pulses"},   mon_pulses - pulse_base, 4);
        check({name, "_bus_viol"},    mon_viol - viol_base, 0);
        check({name, "_latency"},     mon_rsp_cyc - mon_fall_cyc, RESULT_WAIT);
        check({name, "_result"},      rsp_result, res);
        check({name, "_expected"},    rsp_expected, expd);
        check({name, "_mismatch"},    rsp_mismatch, mm);
        for (int i = 0; i < hold; i++) begin
            step();
            check({name, "_hold_valid"},  rsp_valid, 1);
            check({name, "_hold_result"}, rsp_result, res);
            check({name, "_hold_ready"},  req_ready, 0);
            check({name, "_hold_go"},     calc_go, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({name, "_rsp_cleared"}, rsp_valid, 0);
        check({name, "_idle_ready"},  req_ready, 1);
        check({name, "_kept_result"}, rsp_result, res);
    endtask

    typedef struct {
        logic [W-1:0] a, b, c, x;
        logic [W-1:0] res, expd;
        logic         mm;
        int           hold;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n;
        vecs[0] = '{8'd1,   8'd2,   8'd3,   8'd4,   8'd27,  8'd27,  1'b0, 0};
        vecs[1] = '{8'd3,   8'd5,   8'd7,   8'd10,  8'd101, 8'd101, 1'b0, 10};
        vecs[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 0};
        vecs[3] = '{8'd16,  8'd0,   8'd0,   8'd16,  8'd0,   8'd0,   1'b0, 0};
        vecs[4] = '{8'd0,   8'd1,   8'd0,   8'd200, 8'd200, 8'd200, 1'b0, 2};

        // Reset state
        repeat (3) step();
        resetn = 1'b1;
        step();
        check("rst_req_ready",    req_ready, 1);
        check("rst_busy",         busy, 0);
        check("rst_calc_go",      calc_go, 0);
        check("rst_calc_data",    calc_data, 0);
        check("rst_rsp_valid",    rsp_valid, 0);
        check("rst_rsp_result",   rsp_result, 0);
        check("rst_rsp_expected", rsp_expected, 0);
        check("rst_rsp_mismatch", rsp_mismatch, 0);

        // Vector table
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(nm, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x, 1'b0);
            collect(nm, vecs[i].res, vecs[i].expd, vecs[i].mm, vecs[i].hold);
        end

        // Reset while calc_go is high for operand B
        issue("abort", 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        n = 0;
        while (!((mon_pulses - pulse_base == 2) && calc_go) && n < 50) begin
            step();
            n++;
        end
        check("abort_reached_go_b", calc_go, 1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("abort_calc_go",   calc_go, 0);
        check("abort_busy",      busy, 0);
        check("abort_req_ready", req_ready, 1);
        step();
        issue("after_abort", 8'd0, 8'd0, 8'd5, 8'd9, 1'b0);
        collect("after_abort", 8'd5, 8'd5, 1'b0, 0);

        // Back-to-back requests with req_valid held high
        issue("b2b_first", 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        req_a = 8'd2; req_b = 8'd0; req_c = 8'd0; req_x = 8'd3;
        collect("b2b_first", 8'd3, 8'd3, 1'b0, 0);
        check("b2b_idle_gap", busy, 0);
        pulse_base = mon_pulses;
        viol_base  = mon_viol;
        step();
        check("b2b_second_accept", busy, 1);
        req_valid = 1'b0;
        collect("b2b_second", 8'd18, 8'd18, 1'b0, 0);

        // Faulty evaluator: result off by one
        ev_corrupt = 1'b1;
        issue("corrupt", 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        collect("corrupt", 8'd28, 8'd27, 1'b1, 0);
        ev_corrupt = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
